// File: rtl/regbus_bridge.sv
// Host valid/ready slave driving a peripheral core's one-hot register strobes.
// Optional REGBUS_BRIDGE_IRQ_LATCH_EN: sticky interrupt pending bit at address 2**ADDR_W-1.
module regbus_bridge #(
    parameter int REGS   = 3,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [31:0]            host_wdata,
    input  logic                   host_we,
    input  logic                   host_req,
    output logic                   host_ready,
    output logic                   host_ack,
    output logic                   host_err,
    output logic [31:0]            host_rdata,
    output logic [31:0]            core_data_in,
    input  logic [REGS-1:0][31:0]  core_data_out,
    output logic [REGS-1:0]        core_write_en,
    output logic [REGS-1:0]        core_read_en,
    input  logic                   core_irq,
    output logic                   irq_out,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] REGS_A = ADDR_W'(REGS);

    state_t          state_q, state_d;
    logic [REGS-1:0] wr_en_q, wr_en_d;
    logic [REGS-1:0] rd_en_q, rd_en_d;
    logic [31:0]     data_in_q, data_in_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            acc_err_q, acc_err_d;
    logic [REGS-1:0] dec;
    logic            in_range;
    logic            is_irq;
    logic [31:0]     rd_mux;
    logic            irq_q;

`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
    localparam logic [ADDR_W-1:0] IRQ_ADDR = '1;
    logic irq_qq;
    logic pending_q, pending_d;
    logic irq_clr_q, irq_clr_d;
    logic irq_rd_q, irq_rd_d;
`endif

    assign dec      = REGS'(1) << host_addr;
    assign in_range = (host_addr < REGS_A);
`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
    assign is_irq   = (host_addr == IRQ_ADDR);
`else
    assign is_irq   = 1'b0;
`endif

    // Strobes are one-hot, so OR-ing the enabled words is the read mux.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < REGS; i++) begin
            if (rd_en_q[i]) rd_mux = rd_mux | core_data_out[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_en_d   = '0;
        rd_en_d   = '0;
        data_in_d = data_in_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        acc_err_d = acc_err_q;
`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
        pending_d = pending_q;
        irq_clr_d = irq_clr_q;
        irq_rd_d  = irq_rd_q;
`endif
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    state_d   = ACCESS;
                    acc_err_d = !in_range && !is_irq;
                    if (in_range) begin
                        if (host_we) begin
                            wr_en_d   = dec;
                            data_in_d = host_wdata;
                        end else begin
                            rd_en_d   = dec;
                        end
                    end
`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
                    irq_clr_d = is_irq && host_we && host_wdata[0];
                    irq_rd_d  = is_irq && !host_we;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                err_d   = acc_err_q;
                rdata_d = rd_mux;
`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
                if (irq_rd_q)  rdata_d   = {31'b0, pending_q};
                if (irq_clr_q) pending_d = 1'b0;
`endif
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
        // A rising edge overrides a clear in the same cycle.
        if (irq_q && !irq_qq) pending_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_en_q   <= '0;
            rd_en_q   <= '0;
            data_in_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            acc_err_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            data_in_q <= data_in_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            acc_err_q <= acc_err_d;
            irq_q     <= core_irq;
        end
    end

`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_qq    <= 1'b0;
            pending_q <= 1'b0;
            irq_clr_q <= 1'b0;
            irq_rd_q  <= 1'b0;
        end else begin
            irq_qq    <= irq_q;
            pending_q <= pending_d;
            irq_clr_q <= irq_clr_d;
            irq_rd_q  <= irq_rd_d;
        end
    end
    assign irq_out = pending_q;
`else
    assign irq_out = irq_q;
`endif

    assign host_ready    = (state_q == IDLE);
    assign host_ack      = (state_q == RESP);
    assign host_err      = err_q;
    assign host_rdata    = rdata_q;
    assign core_data_in  = data_in_q;
    assign core_write_en = wr_en_q;
    assign core_read_en  = rd_en_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_regbus_bridge.sv
// Randomized bench for regbus_bridge with a transaction-level reference model.
module tb_regbus_bridge;

    localparam int REGS   = 3;
    localparam int ADDR_W = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [ADDR_W-1:0]     host_addr;
    logic [31:0]           host_wdata;
    logic                  host_we;
    logic                  host_req;
    logic                  host_ready;
    logic                  host_ack;
    logic                  host_err;
    logic [31:0]           host_rdata;
    logic [31:0]           core_data_in;
    logic [REGS-1:0][31:0] core_data_out;
    logic [REGS-1:0]       core_write_en;
    logic [REGS-1:0]       core_read_en;
    logic                  core_irq;
    logic                  irq_out;
    logic [1:0]            dbg_state;

    regbus_bridge #(.REGS(REGS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_req(host_req),
        .host_ready(host_ready), .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
        .core_data_in(core_data_in), .core_data_out(core_data_out),
        .core_write_en(core_write_en), .core_read_en(core_read_en),
        .core_irq(core_irq), .irq_out(irq_out), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected response {err, rdata}, pushed at access time, popped at ack.
    logic [32:0] exp_q[$];

    // Reference model state
    logic        m_s1, m_s2, m_pend, m_clr;
    logic [31:0] m_data_in, m_rdata;
    logic        rand_irq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic exp_irq();
`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
        return m_pend;
`else
        return m_s1;
`endif
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_pend = 0; m_clr = 0;
        m_data_in = 0; m_rdata = 0;
    endtask

    // One clock: the model advances on the edge, outputs are sampled on the falling edge.
    task automatic tick();
        logic s_in, c, rise;
        s_in = core_irq;
        c    = m_clr;
        @(posedge clk);
        if (!reset) begin
            m_s1 = 0; m_s2 = 0; m_pend = 0;
        end else begin
            rise   = m_s1 & ~m_s2;
            m_pend = rise | (m_pend & ~c);
            m_s2   = m_s1;
            m_s1   = s_in;
        end
        @(negedge clk);
        check("irq_out", irq_out, exp_irq());
        if (rand_irq && $urandom_range(0, 3) == 0) core_irq = ~core_irq;
    endtask

    task automatic do_txn(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] d);
        logic            valid, is_irq, err;
        logic [31:0]     exp_rd;
        logic [REGS-1:0] exp_w, exp_r;
        logic [32:0]     resp;
        int              waits;
        valid = (int'(a) < REGS);
`ifdef REGBUS_BRIDGE_IRQ_LATCH_EN
        is_irq = (a == {ADDR_W{1'b1}});
`else
        is_irq = 1'b0;
`endif
        waits = 0;
        while (!host_ready && waits < 5) begin
            tick();
            waits++;
        end
        check("ready_before_accept", host_ready, 1);
        host_req = 1; host_addr = a; host_we = w; host_wdata = d;
        tick();
        exp_w = (valid && w)  ? (REGS'(1) << a) : '0;
        exp_r = (valid && !w) ? (REGS'(1) << a) : '0;
        if (valid && w) m_data_in = d;
        check("ready_access", host_ready, 0);
        check("ack_access", host_ack, 0);
        check("write_en", core_write_en, exp_w);
        check("read_en", core_read_en, exp_r);
        check("data_in_access", core_data_in, m_data_in);
        err = !valid && !is_irq;
        if (valid && !w)       exp_rd = core_data_out[int'(a)];
        else if (is_irq && !w) exp_rd = {31'b0, m_pend};
        else                   exp_rd = 32'h0;
        exp_q.push_back({err, exp_rd});
        if (is_irq && w && d[0]) m_clr = 1;
        host_addr = ADDR_W'($urandom); host_we = 1'($urandom); host_wdata = $urandom;
        tick();
        m_clr = 0;
        check("ack_resp", host_ack, 1);
        check("ready_resp", host_ready, 0);
        check("strobes_resp", {core_write_en, core_read_en}, 0);
        if (exp_q.size() == 0) begin
            check("exp_q_underflow", 1, 0);
        end else begin
            resp = exp_q.pop_front();
            check("err", host_err, resp[32]);
            check("rdata", host_rdata, resp[31:0]);
            m_rdata = resp[31:0];
        end
        tick();
        check("ready_idle", host_ready, 1);
        check("ack_idle", host_ack, 0);
        check("err_idle", host_err, 0);
        check("rdata_hold", host_rdata, m_rdata);
        check("data_in_hold", core_data_in, m_data_in);
    endtask

    initial begin
        reset = 0; host_req = 0; host_addr = 0; host_wdata = 0; host_we = 0;
        core_irq = 0; rand_irq = 0;
        for (int i = 0; i < REGS; i++) core_data_out[i] = $urandom;
        model_reset();
        #1;
        check("rst_ready", host_ready, 1);
        check("rst_ack", host_ack, 0);
        check("rst_err", host_err, 0);
        check("rst_rdata", host_rdata, 0);
        check("rst_data_in", core_data_in, 0);
        check("rst_strobes", {core_write_en, core_read_en}, 0);
        check("rst_irq", irq_out, 0);
        tick(); tick();
        reset = 1;
        tick();

        // Directed write, read, out-of-range read and write
        do_txn(4'd1, 1'b1, 32'h0000_0007);
        host_req = 0;
        core_data_out[0] = 32'h0000_1234;
        do_txn(4'd0, 1'b0, 32'h0);
        do_txn(4'd5, 1'b0, 32'h0);
        do_txn(4'd5, 1'b1, 32'hDEAD_BEEF);
        host_req = 0;
        tick();

        // Back-to-back writes with host_req held high
        for (int i = 0; i < 4; i++) do_txn(ADDR_W'(i % REGS), 1'b1, $urandom);
        host_req = 0;
        tick();

        // Reset asserted during ACCESS
        host_req = 1; host_addr = 4'd2; host_we = 1; host_wdata = 32'hA5A5_0002;
        tick();
        check("mid_write_en", core_write_en, 3'b100);
        host_req = 0;
        reset = 0;
        #1;
        check("mid_rst_strobes", {core_write_en, core_read_en}, 0);
        check("mid_rst_ready", host_ready, 1);
        check("mid_rst_ack", host_ack, 0);
        model_reset();
        tick();
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_ack_after_abort", host_ack, 0);
            check("ready_after_abort", host_ready, 1);
        end

        // Interrupt behaviour: rise, fall, clear, set-wins
        core_irq = 1;
        tick(); tick(); tick();
        core_irq = 0;
        tick(); tick();
        do_txn(4'd15, 1'b0, 32'h0);
        do_txn(4'd15, 1'b1, 32'h0);
        do_txn(4'd15, 1'b1, 32'h1);
        host_req = 0;
        core_irq = 1;
        tick(); tick(); tick();
        core_irq = 0;
        tick(); tick();
        core_irq = 1;
        do_txn(4'd15, 1'b1, 32'h1);
        host_req = 0;
        core_irq = 0;
        tick();
        do_txn(4'd15, 1'b0, 32'h0);
        host_req = 0;
        tick();

        // Randomized traffic with a toggling interrupt line
        rand_irq = 1;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < REGS; i++) core_data_out[i] = $urandom;
            do_txn(ADDR_W'($urandom_range(0, 15)), 1'($urandom), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                host_req = 0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        host_req = 0;
        rand_irq = 0;
        tick();
        check("exp_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

endmodule
